// File: rtl/sha_digest_stream_out.sv
// rtl/sha_digest_stream_out.sv - multi-digest FIFO and word serialiser for the SHA core output
// Optional SHA_OUT_BYTESWAP_EN byte-reverses each output word for little-endian hosts.
module sha_digest_stream_out #(
  parameter int DIGEST_W  = 256,
  parameter int WORD_W    = 32,
  parameter int OUT_WORDS = DIGEST_W / WORD_W,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       compression_valid,
  input  logic [DIGEST_W-1:0]        state_in,
  output logic                       ready_for_next,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     digest_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_next;
  logic [DIGEST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_next;
  logic [IDX_W-1:0]    w;
  logic [DIGEST_W-1:0] head;
  logic [WORD_W-1:0]   word, word_out;
  logic                push, pop, xfer;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ready_for_next = (count < CNT_W'(DEPTH));
  assign digest_count   = count;
  assign push           = compression_valid && ready_for_next;
  assign xfer           = out_valid && out_ready;
  assign pop            = xfer && out_last;
  assign head           = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  // State follows the post-edge count so word 0 appears the cycle after the push.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    case (state)
      IDLE: if (count_next != '0) state_next = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (count_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < OUT_WORDS; i++)
      if (w == IDX_W'(i)) word = head[DIGEST_W-1-i*WORD_W -: WORD_W];
  end

`ifdef SHA_OUT_BYTESWAP_EN
  always_comb begin
    word_out = '0;
    for (int b = 0; b < WORD_W / 8; b++)
      word_out[b*8 +: 8] = word[WORD_W-8-b*8 +: 8];
  end
`else
  assign word_out = word;
`endif

  assign out_data = out_valid ? word_out : '0;
  assign out_last = out_valid && (w == IDX_W'(OUT_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      w        <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= pop;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (compression_valid && !ready_for_next) overflow <= 1'b1;
      if (xfer) begin
        if (out_last) begin
          w      <= '0;
          rd_ptr <= next_ptr(rd_ptr);
        end else begin
          w <= w + IDX_W'(1);
        end
      end
    end
  end

  // Digest storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= state_in;
  end

endmodule

// File: doc/sha_digest_stream_out.md
# sha_digest_stream_out

Parametrised output stage for the SHA hash core, placed between the compression engine and the downstream consumer. Buffers up to DEPTH completed digests in a small FIFO and serialises each digest into WORD_W-bit words on a valid/ready stream. Emits a `last` marker on each digest's final word and a one-cycle `done` pulse per digest. Replaces the single-digest, full-width output register with a back-pressure-aware, multi-digest stage.

## Interface
- DIGEST_W, 256: digest width in bits; must be a multiple of WORD_W.
- WORD_W, 32: output word width in bits; must be a multiple of 8.
- OUT_WORDS, DIGEST_W/WORD_W: words emitted per digest, 1..DIGEST_W/WORD_W. Taken from the most significant end, so 7 gives SHA-224 truncation.
- DEPTH, 2: digest FIFO depth; power of two, ≥1.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- compression_valid  in  1  digest on state_in is presented this cycle.
- state_in  in  DIGEST_W  digest; H0 occupies the MSBs.
- ready_for_next  out  1  FIFO not full: count < DEPTH, driven combinationally from the registered count.
- out_data  out  WORD_W  current output word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  current word is the final word of its digest.
- done  out  1  one-cycle pulse after a digest's final word is accepted.
- overflow  out  1  sticky; set when a digest is dropped. Cleared only by rst.
- digest_count  out  $clog2(DEPTH)+1  number of digests held, including the one being serialised.

## Operation
- **Push:**
  - `compression_valid && ready_for_next` writes state_in at the write pointer and advances it.
  - `compression_valid && !ready_for_next` drops the digest and sets overflow. The FIFO is unchanged.
- **FSM IDLE → SEND:** transition when count > 0. out_valid = 1 in SEND only.
- **Serialiser:** word index w runs 0..OUT_WORDS-1.
  - out_data = head[DIGEST_W-1-w*WORD_W -: WORD_W].
  - out_last = (w == OUT_WORDS-1).
- **Handshake:** a word transfers on `out_valid && out_ready`.
  - Non-last word: w increments.
  - Last word: w ← 0, the head is popped, and done is asserted next cycle.
  - If the FIFO remains non-empty after the pop, stay in SEND; otherwise go to IDLE.
- **Hold rule:** while `out_valid && !out_ready`, out_data, out_last and w hold stable.
- **Simultaneous push and final-word pop:** both take effect; count stays the same.
  - When full, ready_for_next is already 0, so the push is dropped and overflow is set. A pop never frees a slot in the same cycle.
- **Pointer wrap:** pointers wrap modulo DEPTH. Full/empty is decided from count, never from pointer equality.
- **Reset:** rst asserted at any time, including mid-digest, empties the FIFO. Partial words are discarded and the FSM returns to IDLE.
- **Reset values:** out_valid=0, out_last=0, out_data=0, done=0, overflow=0, digest_count=0, ready_for_next=1.

## Timing
- **Push latency:** a digest pushed at edge N into an empty FIFO gives out_valid=1 with word 0 from the cycle after N.
- **Throughput:** with out_ready held high, one word per cycle. Back-to-back digests stream with no idle cycle between the last word and the next word 0.
- **done:** a registered single-cycle pulse in the cycle after the last-word transfer edge.
- **Digest latency:** OUT_WORDS cycles from push to final transfer under no back-pressure; done follows one cycle later.
- **ready_for_next:** reflects count after the previous edge. A push and a pop at the same edge are both counted at that edge.

## Configuration
- **SHA_OUT_BYTESWAP_EN defined:** each out_data word is byte-reversed, for a little-endian host. out_last, done and word ordering are unaffected.
- **SHA_OUT_BYTESWAP_EN undefined:** words are emitted big-endian, exactly as sliced from state_in.

## Test plan
- **Single digest, no back-pressure:** push ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad with out_ready=1.
  - Required: 8 words ba7816bf … f20015ad on consecutive cycles; out_last only on f20015ad; done one cycle later; digest_count 1 → 0.
- **Back-pressure:** same digest, out_ready toggling 1,0,0,1…
  - Required: each word holds stable while stalled; exactly 8 transfers; no duplicated or skipped word.
- **Fill and overflow (DEPTH=2, out_ready=0):** push 3 digests.
  - Required: ready_for_next=0 after the 2nd push; the 3rd is dropped; overflow=1; digest_count=2.
  - Then release out_ready: 16 words follow in push order, with done pulsed twice.
- **Simultaneous push and pop at count=1 (not full):** push a new digest on the edge where the last word transfers.
  - Required: digest_count stays 1; next cycle out_data is word 0 of the new digest, with no idle cycle.
- **Truncation (OUT_WORDS=7):**
  - Required: 7 words emitted, out_last on b410ff61; f20015ad is never output.
- **Reset mid-digest:** assert rst after word 3.
  - Required: out_valid=0, digest_count=0 and ready_for_next=1 immediately. A following push restarts at word 0.
